// File: rtl/aes_inv_128_if.sv
// Request/response bundle for the iterative AES-128 inverse cipher.
// The master side issues ciphertext/key with a start pulse; the slave side returns plaintext.
interface aes_inv_128_if;
    logic         start;
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
    logic         done;
    logic         busy;

    modport master (
        output start, ct, key,
        input  pt, done, busy
    );

    modport slave (
        input  start, ct, key,
        output pt, done, busy
    );
endinterface

// File: rtl/aes_inv_128.sv
// Iterative AES-128 inverse cipher: ten cycles of forward key expansion to reach round key 10,
// then ten inverse rounds that walk the key schedule backwards one round key per cycle.
module aes_inv_128 (
    input  logic         clk,
    input  logic         rst,
    aes_inv_128_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Table byte x sits at the top of the packed vector, so index by (255 - x) * 8.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return INV_SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] k);
        case (k)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)): the byte rotation is folded into the byte selection.
    function automatic logic [31:0] subRotWord(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwdKey(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ subRotWord(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] prevKey(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ subRotWord(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    // Row r of the column-major state rotates right by r columns.
    function automatic logic [127:0] invShiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] invSubBytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = invSbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] invMixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2, x4, x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127 - 8 * (4 * c + r) -: 8];
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[127 - 32 * c -: 8]  = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[119 - 32 * c -: 8]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[111 - 32 * c -: 8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[103 - 32 * c -: 8]  = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] st_q, st_d;
    logic [127:0] hold_q, hold_d;
    logic [127:0] pt_q, pt_d;
    logic         done_q, done_d;

    logic [127:0] fwdRk;
    logic [127:0] prevRk;
    logic [127:0] roundOut;

    // Decrypt counter c walks round r = 9 - c, whose previous key needs rcon[r + 1] = rcon[10 - c].
    assign fwdRk    = fwdKey(rk_q, rcon(cnt_q + 4'd1));
    assign prevRk   = prevKey(rk_q, rcon(4'd10 - cnt_q));
    assign roundOut = invSubBytes(invShiftRows(st_q)) ^ prevRk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rk_q    <= '0;
            st_q    <= '0;
            hold_q  <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rk_q    <= rk_d;
            st_q    <= st_d;
            hold_q  <= hold_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rk_d    = rk_q;
        st_d    = st_q;
        hold_d  = hold_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    hold_d  = bus.ct;
                    rk_d    = bus.key;
                    cnt_d   = '0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                rk_d  = fwdRk;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    st_d    = hold_q ^ fwdRk;
                    cnt_d   = '0;
                    state_d = DECRYPT;
                end
            end
            DECRYPT: begin
                rk_d  = prevRk;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    st_d    = roundOut;
                    pt_d    = roundOut;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    st_d = invMixColumns(roundOut);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.pt   = pt_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_aes_inv_128.sv
// Directed bench for aes_inv_128: FIPS-197 vectors, busy/back-to-back starts, reset aborts,
// edge keys and a loopback through an independent forward AES model.
module tb_aes_inv_128;

    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_CT     = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] ALL_ONES = {128{1'b1}};

    logic clk;
    logic rst;
    int   numCompared;
    int   numMismatched;
    logic [127:0] rkAfterExpand;
    logic [7:0]   sboxTb [256];

    aes_inv_128_if bus ();

    aes_inv_128 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait loop is ever bypassed.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse plus affine map, independent of any table.
    task automatic buildSbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sboxTb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aesEnc(input logic [127:0] p, input logic [127:0] key);
        logic [127:0] s, ns, k;
        logic [31:0]  w3, t, k0, k1, k2, k3;
        logic [7:0]   rc, a0, a1, a2, a3;
        s  = p ^ key;
        k  = key;
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            w3 = k[31:0];
            t  = {sboxTb[w3[23:16]], sboxTb[w3[15:8]], sboxTb[w3[7:0]], sboxTb[w3[31:24]]} ^ {rc, 24'h0};
            k0 = k[127:96] ^ t;
            k1 = k[95:64] ^ k0;
            k2 = k[63:32] ^ k1;
            k3 = k[31:0] ^ k2;
            k  = {k0, k1, k2, k3};
            rc = gmul(rc, 8'h02);
            ns = '0;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    ns[127 - 8 * (4 * c + r) -: 8] = sboxTb[s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]];
            if (rnd < 10) begin
                s = ns;
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127 - 32 * c -: 8];
                    a1 = s[119 - 32 * c -: 8];
                    a2 = s[111 - 32 * c -: 8];
                    a3 = s[103 - 32 * c -: 8];
                    ns[127 - 32 * c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    ns[119 - 32 * c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    ns[111 - 32 * c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    ns[103 - 32 * c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            s = ns ^ k;
        end
        return s;
    endfunction

    // Presents a request for one cycle (E0), then scrambles the bus to prove the inputs were latched.
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] key);
        @(negedge clk);
        bus.ct    = ct;
        bus.key   = key;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.ct    = ~ct;
        bus.key   = ~key;
    endtask

    task automatic waitDone(input logic [127:0] prevPt, output int doneEdge, output int busyCycles,
                            output logic ptMoved);
        doneEdge   = -1;
        busyCycles = 0;
        ptMoved    = 1'b0;
        if (bus.busy) busyCycles++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) rkAfterExpand = dut.rk_q;
            if (bus.done) begin
                doneEdge = i;
                break;
            end
            if (bus.pt !== prevPt) ptMoved = 1'b1;
            if (bus.busy) busyCycles++;
        end
    endtask

    task automatic runOp(input string tag, input logic [127:0] ct, input logic [127:0] key,
                         output logic [127:0] got);
        logic [127:0] prevPt;
        int           doneEdge, busyCycles;
        logic         ptMoved;
        prevPt = bus.pt;
        applyStimulus(ct, key);
        waitDone(prevPt, doneEdge, busyCycles, ptMoved);
        got = bus.pt;
        checkOutput({tag, "/latency"}, 128'(doneEdge), 128'd20);
        checkOutput({tag, "/busyCycles"}, 128'(busyCycles), 128'd20);
        checkOutput({tag, "/ptHold"}, {127'd0, ptMoved}, 128'd0);
        checkOutput({tag, "/rkRestored"}, dut.rk_q, key);
        @(posedge clk);
        #1;
        checkOutput({tag, "/donePulse"}, {127'd0, bus.done}, 128'd0);
        checkOutput({tag, "/ptKept"}, bus.pt, got);
    endtask

    task automatic abortRun(input string tag, input int edgeNum);
        int           strayDone;
        logic [127:0] got;
        applyStimulus(C1_CT, C1_KEY);
        repeat (edgeNum - 1) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput({tag, "/pt"}, bus.pt, 128'd0);
        checkOutput({tag, "/done"}, {127'd0, bus.done}, 128'd0);
        checkOutput({tag, "/busy"}, {127'd0, bus.busy}, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        strayDone = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done) strayDone++;
        end
        checkOutput({tag, "/strayDone"}, 128'(strayDone), 128'd0);
        runOp({tag, "/rerun"}, C1_CT, C1_KEY, got);
        checkOutput({tag, "/rerunPt"}, got, C1_PT);
    endtask

    initial begin
        logic [127:0] got, p, k;
        int           doneCnt, firstEdge, secondEdge;
        logic [127:0] firstPt, secondPt;
        logic         prevDone, doubleDone;

        numCompared   = 0;
        numMismatched = 0;
        rkAfterExpand = '0;
        bus.start     = 1'b0;
        bus.ct        = '0;
        bus.key       = '0;
        rst           = 1'b1;
        buildSbox();

        #2 rst = 1'b0;
        #10;
        checkOutput("reset/pt", bus.pt, 128'd0);
        checkOutput("reset/done", {127'd0, bus.done}, 128'd0);
        checkOutput("reset/busy", {127'd0, bus.busy}, 128'd0);
        checkOutput("reset/rk", dut.rk_q, 128'd0);
        checkOutput("reset/st", dut.st_q, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        runOp("c1", C1_CT, C1_KEY, got);
        checkOutput("c1/pt", got, C1_PT);

        runOp("appB", B_CT, B_KEY, got);
        checkOutput("appB/pt", got, B_PT);
        checkOutput("appB/rk10", rkAfterExpand, B_RK10);

        // Starts at E5 and E20 must be ignored; the one at E21 is accepted.
        applyStimulus(C1_CT, C1_KEY);
        doneCnt    = 0;
        firstEdge  = -1;
        secondEdge = -1;
        firstPt    = '0;
        secondPt   = '0;
        prevDone   = 1'b0;
        doubleDone = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (e == 5 || e == 20) begin
                bus.start = 1'b1;
                bus.ct    = 128'hdeadbeef_01234567_89abcdef_cafef00d;
                bus.key   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
            end else if (e == 21) begin
                bus.start = 1'b1;
                bus.ct    = B_CT;
                bus.key   = B_KEY;
            end
            @(posedge clk);
            #1;
            if (bus.done && prevDone) doubleDone = 1'b1;
            prevDone = bus.done;
            if (bus.done) begin
                doneCnt++;
                if (firstEdge < 0) begin
                    firstEdge = e;
                    firstPt   = bus.pt;
                end else if (secondEdge < 0) begin
                    secondEdge = e;
                    secondPt   = bus.pt;
                end
            end
        end
        bus.start = 1'b0;
        checkOutput("b2b/firstEdge", 128'(firstEdge), 128'd20);
        checkOutput("b2b/firstPt", firstPt, C1_PT);
        checkOutput("b2b/secondEdge", 128'(secondEdge), 128'd41);
        checkOutput("b2b/secondPt", secondPt, B_PT);
        checkOutput("b2b/doneCount", 128'(doneCnt), 128'd2);
        checkOutput("b2b/doubleDone", {127'd0, doubleDone}, 128'd0);

        abortRun("abortExpand", 10);
        abortRun("abortDecrypt", 15);

        runOp("zeroKey", Z_CT, 128'd0, got);
        checkOutput("zeroKey/pt", got, 128'd0);
        runOp("allZero", 128'd0, 128'd0, got);
        checkOutput("allZero/roundTrip", aesEnc(got, 128'd0), 128'd0);
        runOp("allOnes", ALL_ONES, ALL_ONES, got);
        checkOutput("allOnes/roundTrip", aesEnc(got, ALL_ONES), ALL_ONES);

        for (int n = 0; n < 12; n++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            runOp($sformatf("loop%0d", n), aesEnc(p, k), k, got);
            checkOutput($sformatf("loop%0d/pt", n), got, p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
